// File: rtl/sram_ctrl_1024x8.sv
// Synchronous initiator for an asynchronous 1024x8 SRAM port.
// Turns single-beat valid/ready requests into SETUP/ACCESS/TURN bus cycles.
// All SRAM-side pins and the data_io output enable come straight from flops.
module sram_ctrl_1024x8 #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    inout  wire  [DATA_W-1:0] data_io,
    output logic [ADDR_W-1:0] address,
    output logic              read_write_select,
    output logic              chip_select
);

    localparam int unsigned WCNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int unsigned TCNT_W = $clog2(TURN_CYCLES + 1);

    // Reject unusable parameter sets at elaboration
    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_ctrl_1024x8: WAIT_CYCLES must be >= 1");
    end
    if (TURN_CYCLES < 1) begin : g_bad_turn
        $error("sram_ctrl_1024x8: TURN_CYCLES must be >= 1");
    end
    if (ADDR_W < 1 || DATA_W < 1) begin : g_bad_width
        $error("sram_ctrl_1024x8: ADDR_W and DATA_W must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        TURN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] rdata_d;
    logic              rsp_valid_d;
    logic              busy_d;
    logic              ready_d;
    logic              cs_d;
    logic              rws_d;

    // Bus is driven only while a write is in flight (SETUP through TURN)
    assign data_io = oe_q ? wdata_q : {DATA_W{1'bz}};

    // Next state, counters and next values of every registered output
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        addr_d      = address;
        rdata_d     = rsp_rdata;
        rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = SETUP;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wcnt_d  = '0;
            end
            ACCESS: begin
                if (wcnt_q == WCNT_W'(WAIT_CYCLES - 1)) begin
                    state_d     = TURN;
                    tcnt_d      = '0;
                    rsp_valid_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d = data_io;
                    end
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            TURN: begin
                if (tcnt_q == TCNT_W'(TURN_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values follow the state being entered so they change on the same edge
        busy_d  = (state_d != IDLE);
        ready_d = !busy_d;
        cs_d    = (state_d == ACCESS);
        rws_d   = busy_d ? !wr_d : 1'b1;
        oe_d    = busy_d && wr_d;
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            wcnt_q            <= '0;
            tcnt_q            <= '0;
            wr_q              <= 1'b0;
            wdata_q           <= '0;
            oe_q              <= 1'b0;
            address           <= '0;
            rsp_rdata         <= '0;
            rsp_valid         <= 1'b0;
            busy              <= 1'b0;
            req_ready         <= 1'b0;
            chip_select       <= 1'b0;
            read_write_select <= 1'b1;
        end else begin
            state_q           <= state_d;
            wcnt_q            <= wcnt_d;
            tcnt_q            <= tcnt_d;
            wr_q              <= wr_d;
            wdata_q           <= wdata_d;
            oe_q              <= oe_d;
            address           <= addr_d;
            rsp_rdata         <= rdata_d;
            rsp_valid         <= rsp_valid_d;
            busy              <= busy_d;
            req_ready         <= ready_d;
            chip_select       <= cs_d;
            read_write_select <= rws_d;
        end
    end

endmodule

// File: tb/tb_sram_ctrl_1024x8.sv
// Bench for sram_ctrl_1024x8: async SRAM models on both buses, a timeline
// model of the default controller checked every cycle, plus directed literals.
module tb_sram_ctrl_1024x8;

    localparam int W      = 2;
    localparam int T      = 1;
    localparam int IDLE_K = W + T + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    // Instance A (defaults)
    logic       req_valid = 1'b0, req_write = 1'b0;
    logic [9:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready, rsp_valid, busy, read_write_select, chip_select;
    logic [7:0] rsp_rdata;
    logic [9:0] address;
    wire  [7:0] data_io;

    // Instance B (WAIT_CYCLES=4, TURN_CYCLES=2)
    logic       b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [9:0] b_req_addr = '0;
    logic [7:0] b_req_wdata = '0;
    logic       b_req_ready, b_rsp_valid, b_busy, b_rws, b_cs;
    logic [7:0] b_rsp_rdata;
    logic [9:0] b_address;
    wire  [7:0] b_data_io;

    sram_ctrl_1024x8 dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .data_io(data_io), .address(address),
        .read_write_select(read_write_select), .chip_select(chip_select)
    );

    sram_ctrl_1024x8 #(.WAIT_CYCLES(4), .TURN_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .busy(b_busy),
        .data_io(b_data_io), .address(b_address),
        .read_write_select(b_rws), .chip_select(b_cs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Async SRAM models: read while CS & RWS; a write commits when CS ends with RWS still low
    logic [7:0] sram_a [1024];
    logic [7:0] sram_b [1024];
    logic [7:0] ref_mem [1024];
    logic       pend_a = 1'b0, pend_b = 1'b0;
    logic [9:0] pa_a, pa_b;
    logic [7:0] pd_a, pd_b;

    assign data_io   = (chip_select && read_write_select) ? sram_a[address] : 8'hzz;
    assign b_data_io = (b_cs && b_rws) ? sram_b[b_address] : 8'hzz;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_a[i]  = init_val(i);
            sram_b[i]  = init_val(i);
            ref_mem[i] = init_val(i);
        end
    end

    // SRAM write capture/commit, sampled mid-cycle
    always @(negedge clk) begin
        if (chip_select && !read_write_select) begin
            pend_a <= 1'b1; pa_a <= address; pd_a <= data_io;
        end else if (pend_a) begin
            pend_a <= 1'b0;
            if (!read_write_select) sram_a[pa_a] <= pd_a;
        end
        if (b_cs && !b_rws) begin
            pend_b <= 1'b1; pa_b <= b_address; pd_b <= b_data_io;
        end else if (pend_b) begin
            pend_b <= 1'b0;
            if (!b_rws) sram_b[pa_b] <= pd_b;
        end
    end

    // Timeline model of instance A: k = cycles since the accepting edge
    int         k = IDLE_K;
    logic       rst_last = 1'b1;
    logic       mdl_ok = 1'b0;
    logic       m_wr = 1'b0;
    logic [9:0] m_addr = '0;
    logic [7:0] m_wdata = '0, m_rdata = '0;

    function automatic logic mdl_ready();
        return (k >= IDLE_K) && !rst_last;
    endfunction

    always @(posedge clk) begin
        rst_last <= rst;
        if (rst) begin
            mdl_ok  <= 1'b1;
            k       <= IDLE_K;
            m_addr  <= '0;
            m_rdata <= '0;
        end else if (mdl_ready() && req_valid) begin
            k       <= 0;
            m_wr    <= req_write;
            m_addr  <= req_addr;
            m_wdata <= req_wdata;
        end else if (k < IDLE_K) begin
            k <= k + 1;
            if (k == W) begin
                if (m_wr) ref_mem[m_addr] <= m_wdata;
                else      m_rdata <= ref_mem[m_addr];
            end
        end
    end

    // Per-cycle compare of instance A against the model, plus bus-rule checks
    logic cs_prev = 1'b0, rws_prev = 1'b1;
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("req_ready", 32'(req_ready), 32'(mdl_ready()));
            chk("busy", 32'(busy), 32'(k < IDLE_K));
            chk("chip_select", 32'(chip_select), 32'(k >= 1 && k <= W));
            chk("rws", 32'(read_write_select), 32'((k < IDLE_K) ? !m_wr : 1'b1));
            chk("address", 32'(address), 32'(m_addr));
            chk("rsp_valid", 32'(rsp_valid), 32'(k == W + 1));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            chk("bus_oe", 32'(dut_a.oe_q), 32'((k < IDLE_K) && m_wr));
            if ((k < IDLE_K) && m_wr) chk("data_io", 32'(data_io), 32'(m_wdata));
            chk("oe_vs_rws", 32'(dut_a.oe_q && read_write_select), 32'(0));
            if (cs_prev && chip_select) chk("rws_stable", 32'(read_write_select), 32'(rws_prev));
            cs_prev  = chip_select;
            rws_prev = read_write_select;
        end
    end

    int acc_cnt = 0;
    always @(posedge clk) if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;

    // Present a request and return right after the accepting edge
    task automatic do_req(input logic w, input logic [9:0] a, input logic [7:0] d, output int c_acc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'(1));
        @(posedge clk); #1;
        c_acc = cyc;
    endtask

    // Wait for the response pulse; report latency, data and pulse width
    task automatic wait_rsp(input int c_acc, output int lat, output logic [7:0] dat);
        int n = 0;
        while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'(1));
        lat = cyc - c_acc;
        dat = rsp_rdata;
        @(negedge clk);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'(0));
    endtask

    task automatic do_b(input logic w, input logic [9:0] a, input logic [7:0] d,
                        output int cs_n, output int lat, output int rv_n, output logic [7:0] rd);
        int n = 0;
        int c0;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = w; b_req_addr = a; b_req_wdata = d;
        while (!b_req_ready && n < 100) begin @(negedge clk); n++; end
        if (!b_req_ready) chk("b_accept_timeout", 32'(b_req_ready), 32'(1));
        @(posedge clk); #1;
        c0 = cyc; cs_n = 0; rv_n = 0; lat = -1; rd = '0;
        @(negedge clk);
        b_req_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (b_cs) cs_n++;
            if (b_rsp_valid) begin rv_n++; lat = cyc - c0; rd = b_rsp_rdata; end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, lat, cs_n, rv_n, acc0;
        logic [7:0] dat;
        logic       w;
        logic [9:0] a;
        logic [7:0] d;

        // Reset values
        @(negedge clk); @(negedge clk);
        chk("rst_cs", 32'(chip_select), 32'(0));
        chk("rst_rws", 32'(read_write_select), 32'(1));
        chk("rst_addr", 32'(address), 32'(0));
        chk("rst_ready", 32'(req_ready), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rdata", 32'(rsp_rdata), 32'(0));
        chk("rst_oe", 32'(dut_a.oe_q), 32'(0));
        rst = 1'b0;

        // Write then read the top address
        do_req(1'b1, 10'h3FF, 8'hA5, c0);
        @(negedge clk); req_valid = 1'b0;
        wait_rsp(c0, lat, dat);
        chk("t1_write_latency", 32'(lat), 32'(3));
        do_req(1'b0, 10'h3FF, 8'h00, c1);
        @(negedge clk); req_valid = 1'b0;
        wait_rsp(c1, lat, dat);
        chk("t1_read_latency", 32'(lat), 32'(3));
        chk("t1_read_data", 32'(dat), 32'h0000_00A5);

        // Back-to-back with req_valid held: accepts W+T+2 = 5 cycles apart
        do_req(1'b1, 10'h000, 8'h5A, c0);
        do_req(1'b0, 10'h000, 8'h00, c1);
        @(negedge clk); req_valid = 1'b0;
        chk("t2_accept_gap", 32'(c1 - c0), 32'(5));
        wait_rsp(c1, lat, dat);
        chk("t2_read_data", 32'(dat), 32'h0000_005A);

        // Inputs changed while busy must be ignored
        repeat (2) @(negedge clk);
        acc0 = acc_cnt;
        do_req(1'b1, 10'h020, 8'h11, c0);
        @(negedge clk); req_addr = 10'h021; req_wdata = 8'h99;
        repeat (2) @(negedge clk);
        @(negedge clk); req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_single_accept", 32'(acc_cnt - acc0), 32'(1));
        chk("t3_mem_latched", 32'(sram_a[10'h020]), 32'h0000_0011);
        chk("t3_mem_untouched", 32'(sram_a[10'h021]), 32'h0000_00D0);

        // Reset in the second ACCESS cycle of a write aborts it
        do_req(1'b1, 10'h010, 8'hFF, c0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("t4_cs_drop", 32'(chip_select), 32'(0));
        chk("t4_bus_released", 32'(dut_a.oe_q), 32'(0));
        chk("t4_no_rsp", 32'(rsp_valid), 32'(0));
        @(negedge clk); rst = 1'b0;
        do_req(1'b0, 10'h010, 8'h00, c1);
        @(negedge clk); req_valid = 1'b0;
        wait_rsp(c1, lat, dat);
        chk("t4_old_value", 32'(dat), 32'h0000_005B);

        // Random traffic under the per-cycle checker
        for (int i = 0; i < 500; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 10'($urandom_range(0, 1023));
            d = 8'($urandom);
            do_req(w, a, d, c0);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        @(negedge clk); req_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Longer timing: WAIT_CYCLES=4, TURN_CYCLES=2
        do_b(1'b1, 10'h123, 8'h3C, cs_n, lat, rv_n, dat);
        chk("t6_write_cs_cycles", 32'(cs_n), 32'(4));
        chk("t6_write_latency", 32'(lat), 32'(5));
        chk("t6_write_rsp_count", 32'(rv_n), 32'(1));
        do_b(1'b0, 10'h123, 8'h00, cs_n, lat, rv_n, dat);
        chk("t6_read_cs_cycles", 32'(cs_n), 32'(4));
        chk("t6_read_latency", 32'(lat), 32'(5));
        chk("t6_read_data", 32'(dat), 32'h0000_003C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
